rv_mem_responder: RTL and testbench

- Memory-side responder for the multicycle RISC-V core: one unified word-addressed memory serving both the instruction-fetch port and the data port.
- Each port uses a req/ready handshake, a programmable wait-state latency, byte-enable writes and error reporting on bad addresses.
- Sits between the core/control pair and the memory array, and replaces the ideal zero-latency memory used in simulation so the control FSM can be exercised against stalls.

---
 rtl/rv_mem_responder.sv | 140 ++++++++++++++
 tb/tb_rv_mem_responder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rv_mem_responder.sv
// Unified instruction/data memory responder with wait states.
// Round-robin arbitration, byte-enable writes and bad-address errors.
module rv_mem_responder #(
  parameter int DPWIDTH     = 32,
  parameter int MEMWORDS    = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_req,
  input  logic [DPWIDTH-1:0]   imem_addr,
  output logic [DPWIDTH-1:0]   imem_rdata,
  output logic                 imem_ready,
  output logic                 imem_err,
  input  logic                 dmem_req,
  input  logic                 dmem_we,
  input  logic [DPWIDTH/8-1:0] dmem_be,
  input  logic [DPWIDTH-1:0]   dmem_addr,
  input  logic [DPWIDTH-1:0]   dmem_wdata,
  output logic [DPWIDTH-1:0]   dmem_rdata,
  output logic                 dmem_ready,
  output logic                 dmem_err
);
  localparam int AW = $clog2(MEMWORDS);
  localparam int BW = DPWIDTH / 8;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [CW-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? CW'(WAIT_CYCLES - 1) : '0;

  logic [1:0]         state;
  logic [CW-1:0]      cnt;
  logic               last_d;
  logic               port_d;
  logic [DPWIDTH-1:0] addr_q;
  logic               we_q;
  logic [BW-1:0]      be_q;
  logic [DPWIDTH-1:0] wdata_q;
  logic [DPWIDTH-1:0] mem [MEMWORDS];

  logic               accept;
  logic               sel_d;
  logic               cur_d;
  logic [DPWIDTH-1:0] cur_addr;
  logic               cur_we;
  logic [BW-1:0]      cur_be;
  logic [DPWIDTH-1:0] cur_wdata;
  logic               access;
  logic               bad;
  logic [AW-1:0]      idx;

  always_comb begin
    accept = !rst && state == IDLE && (imem_req || dmem_req);
    sel_d  = dmem_req && (!imem_req || !last_d);
    // Zero wait states access the array on the acceptance edge itself
    if (state == IDLE) begin
      cur_d     = sel_d;
      cur_addr  = sel_d ? dmem_addr : imem_addr;
      cur_we    = sel_d && dmem_we;
      cur_be    = dmem_be;
      cur_wdata = dmem_wdata;
    end else begin
      cur_d     = port_d;
      cur_addr  = addr_q;
      cur_we    = we_q;
      cur_be    = be_q;
      cur_wdata = wdata_q;
    end
    access = !rst &&
             ((accept && WAIT_CYCLES == 0) ||
              (state == BUSY && cnt == '0));
    bad = (cur_addr[1:0] != 2'b00) ||
          (cur_addr[DPWIDTH-1:AW+2] != '0);
    idx = cur_addr[AW+1:2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      last_d     <= 1'b0;
      port_d     <= 1'b0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      imem_ready <= 1'b0;
      dmem_ready <= 1'b0;
      imem_err   <= 1'b0;
      dmem_err   <= 1'b0;
      imem_rdata <= '0;
      dmem_rdata <= '0;
    end else begin
      imem_ready <= 1'b0;
      dmem_ready <= 1'b0;
      imem_err   <= 1'b0;
      dmem_err   <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          port_d  <= sel_d;
          last_d  <= sel_d;
          addr_q  <= cur_addr;
          we_q    <= cur_we;
          be_q    <= cur_be;
          wdata_q <= cur_wdata;
          cnt     <= CNT_INIT;
          state   <= (WAIT_CYCLES == 0) ? RESP : BUSY;
        end
        BUSY: begin
          if (cnt == '0) state <= RESP;
          else cnt <= cnt - 1'b1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
      if (access) begin
        if (cur_d) begin
          dmem_ready <= 1'b1;
          dmem_err   <= bad;
          if (bad) dmem_rdata <= '0;
          else if (!cur_we) dmem_rdata <= mem[idx];
        end else begin
          imem_ready <= 1'b1;
          imem_err   <= bad;
          imem_rdata <= bad ? '0 : mem[idx];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (access && cur_we && !bad) begin
      for (int i = 0; i < BW; i++) begin
        if (cur_be[i]) mem[idx][8*i +: 8] <= cur_wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_rv_mem_responder.sv
// Randomized bench for rv_mem_responder against a transaction-level
// memory model with round-robin and fixed-latency expectations.
module tb_rv_mem_responder;
  localparam int WC = 2;
  localparam int MW = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req = 1'b0;
  logic [31:0] imem_addr = '0;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        imem_err;
  logic        dmem_req = 1'b0;
  logic        dmem_we = 1'b0;
  logic [3:0]  dmem_be = '0;
  logic [31:0] dmem_addr = '0;
  logic [31:0] dmem_wdata = '0;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  logic        dmem_err;

  int total = 0;
  int bad = 0;
  logic [31:0] mref [int];
  bit lg_d = 1'b0;

  rv_mem_responder #(
    .DPWIDTH(32), .MEMWORDS(MW), .WAIT_CYCLES(WC)
  ) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .imem_err(imem_err),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_be(dmem_be),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .dmem_err(dmem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a >= 32'(4 * MW));
  endfunction

  task automatic expect_of(input bit d, input logic [31:0] a,
                           input bit we, output bit err,
                           output bit chk_rd, output logic [31:0] rd);
    int k;
    k = int'(a >> 2);
    err = is_bad(a);
    rd = '0;
    if (err) chk_rd = 1'b1;
    else if (d && we) chk_rd = 1'b0;
    else begin
      chk_rd = mref.exists(k);
      if (chk_rd) rd = mref[k];
    end
  endtask

  task automatic apply_wr(input logic [31:0] a, input logic [3:0] be,
                          input logic [31:0] wd);
    int k;
    logic [31:0] w;
    k = int'(a >> 2);
    if (is_bad(a)) return;
    if (!mref.exists(k) && be != 4'hF) return;
    w = mref.exists(k) ? mref[k] : 32'h0;
    for (int i = 0; i < 4; i++)
      if (be[i]) w[8*i +: 8] = wd[8*i +: 8];
    mref[k] = w;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", {30'd0, imem_ready, dmem_ready}, 32'd0);
      chk("rst_err", {30'd0, imem_err, dmem_err}, 32'd0);
      chk("rst_irdata", imem_rdata, 32'd0);
      chk("rst_drdata", dmem_rdata, 32'd0);
    end
    rst = 1'b0;
    lg_d = 1'b0;
  endtask

  task automatic wait_resp(input bit exp_d, input int exp_lat,
                           input bit exp_err, input bit chk_rd,
                           input logic [31:0] exp_rd, input bit scramble);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      if (imem_ready || dmem_ready) seen = 1'b1;
      else if (scramble && n == 1) begin
        dmem_addr  = $urandom;
        dmem_wdata = $urandom;
        dmem_we    = 1'($urandom);
        dmem_be    = 4'($urandom);
        imem_addr  = $urandom;
      end
    end
    chk("timeout", 32'(seen), 32'd1);
    if (seen) begin
      chk("latency", n, exp_lat);
      chk("dready", 32'(dmem_ready), 32'(exp_d));
      chk("iready", 32'(imem_ready), 32'(!exp_d));
      chk("err", 32'(exp_d ? dmem_err : imem_err), 32'(exp_err));
      chk("idle_err", 32'(exp_d ? imem_err : dmem_err), 32'd0);
      if (chk_rd) chk("rdata", exp_d ? dmem_rdata : imem_rdata, exp_rd);
      if (exp_d) dmem_req = 1'b0;
      else imem_req = 1'b0;
    end
  endtask

  task automatic serve(input bit d, input int lat, input bit scr,
                       input logic [31:0] ia, input bit we,
                       input logic [3:0] be, input logic [31:0] da,
                       input logic [31:0] wd);
    bit e, c;
    logic [31:0] r;
    expect_of(d, d ? da : ia, d && we, e, c, r);
    wait_resp(d, lat, e, c, r, scr);
    if (d && we) apply_wr(da, be, wd);
    lg_d = d;
  endtask

  task automatic do_txn(input bit ui, input bit ud,
                        input logic [31:0] ia, input bit we,
                        input logic [3:0] be, input logic [31:0] da,
                        input logic [31:0] wd);
    bit first_d;
    @(negedge clk);
    imem_addr  = ia;
    dmem_we    = we;
    dmem_be    = be;
    dmem_addr  = da;
    dmem_wdata = wd;
    imem_req   = ui;
    dmem_req   = ud;
    first_d = (ui && ud) ? !lg_d : ud;
    serve(first_d, WC + 1, !(ui && ud), ia, we, be, da, wd);
    if (ui && ud) serve(!first_d, WC + 2, 1'b0, ia, we, be, da, wd);
  endtask

  function automatic logic [31:0] rnd_addr();
    int p;
    p = $urandom_range(0, 19);
    if (p < 16) return 32'(p * 4);
    if (p == 16) return 32'(4 * MW - 4);
    if (p == 17) return 32'(4 * $urandom_range(0, 15) + $urandom_range(1, 3));
    return 32'(4 * MW + 4 * $urandom_range(0, 255));
  endfunction

  initial begin
    // Reset with a write already pending on the data port
    dmem_req = 1'b1; dmem_we = 1'b1; dmem_be = 4'hF;
    dmem_addr = 32'h40; dmem_wdata = 32'h0;
    do_reset();
    serve(1'b1, WC + 1, 1'b0, 32'h0, 1'b1, 4'hF, 32'h40, 32'h0);

    do_txn(0, 1, 0, 1, 4'hF, 32'h10, 32'hDEADBEEF);
    do_txn(0, 1, 0, 0, 4'hF, 32'h10, 32'h0);
    do_txn(0, 1, 0, 1, 4'hF, 32'h20, 32'h11223344);
    do_txn(0, 1, 0, 1, 4'b0010, 32'h20, 32'h0000AA00);
    do_txn(0, 1, 0, 0, 4'h0, 32'h20, 32'h0);
    do_txn(0, 1, 0, 1, 4'h0, 32'h20, 32'hFFFFFFFF);
    do_txn(0, 1, 0, 0, 4'hF, 32'h20, 32'h0);
    chk("bytelane_model", mref[8], 32'h1122AA44);

    do_reset();
    do_txn(1, 1, 32'h10, 0, 4'hF, 32'h20, 32'h0);
    do_txn(1, 1, 32'h20, 0, 4'hF, 32'h10, 32'h0);

    do_txn(0, 1, 0, 1, 4'hF, 32'h22, 32'h55555555);
    do_txn(0, 1, 0, 0, 4'hF, 32'h20, 32'h0);
    do_txn(1, 0, 32'(4 * MW), 0, 4'h0, 0, 32'h0);

    // Reset lands while the write is still counting down
    @(negedge clk);
    dmem_we = 1'b1; dmem_be = 4'hF;
    dmem_addr = 32'h40; dmem_wdata = 32'hCAFEF00D;
    dmem_req = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    dmem_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_ready", {30'd0, imem_ready, dmem_ready}, 32'd0);
    end
    rst = 1'b0;
    lg_d = 1'b0;
    do_txn(0, 1, 0, 0, 4'hF, 32'h40, 32'h0);

    for (int i = 0; i < 16; i++)
      do_txn(0, 1, 0, 1, 4'hF, 32'(4 * i), $urandom);
    do_txn(0, 1, 0, 1, 4'hF, 32'(4 * MW - 4), $urandom);

    for (int t = 0; t < 80; t++) begin
      int m;
      m = $urandom_range(0, 2);
      do_txn(m != 1, m != 0, rnd_addr(), 1'($urandom),
             4'($urandom), rnd_addr(), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
